// File: rtl/anton_neopixel_bus_arbiter.sv
// Two-requester arbiter for the byte-wide neopixel register/pixel bus.
// m0 is the CPU bridge and m1 is the animation/DMA engine. Each granted request
// becomes one single-beat read or write on the bus. Every output is registered.
//
// Handshake: a requester raises mXReq with mXWrite/mXAddr/mXDataIn and holds
// them stable until mXAck. mXAck is a one-cycle pulse. In the cycle after its
// ack, the requester must drop mXReq or replace the payload. The arbiter only
// samples requests in IDLE, so changes from a requester that has not been
// granted are ignored until then.
module anton_neopixel_bus_arbiter #(
  parameter bit ROUND_ROBIN = 1'b1,
  parameter bit GUARD_REGS  = 1'b1
) (
  input  logic        busClk,
  input  logic        busResetN,
  input  logic        m0Req,
  input  logic        m0Write,
  input  logic [13:0] m0Addr,
  input  logic [7:0]  m0DataIn,
  output logic        m0Ack,
  input  logic        m1Req,
  input  logic        m1Write,
  input  logic [13:0] m1Addr,
  input  logic [7:0]  m1DataIn,
  output logic        m1Ack,
  output logic [7:0]  rdData,
  output logic        m1Err,
  output logic        busy,
  output logic [13:0] busAddr,
  output logic [7:0]  busDataIn,
  output logic        busWrite,
  output logic        busRead,
  input  logic [7:0]  busDataOut,
  output logic [1:0]  dbgState
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_CAPTURE = 2'd2,
    S_ACK     = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  // Transaction latched at grant time. r_id: 0 = m0, 1 = m1.
  logic        r_id;
  logic        r_write;
  logic        r_guard;
  logic [13:0] r_addr;
  logic [7:0]  r_data;
  logic        r_last_grant;

  logic [7:0]  r_rd_data;
  logic        r_m0_ack;
  logic        r_m1_ack;
  logic        r_m1_err;
  logic        r_busy;
  logic        r_bus_write;
  logic        r_bus_read;

  logic        w_any_req;
  logic        w_win;
  logic        w_win_write;
  logic        w_win_guard;
  logic        w_grant;
  logic [13:0] w_win_addr;
  logic [7:0]  w_win_data;

  // Choose a winner and steer its payload. A tie goes to the requester that was not granted last, or always to m0 when round robin is disabled.
  always_comb begin
    w_any_req = m0Req | m1Req;
    if (m0Req && m1Req) begin
      w_win = ROUND_ROBIN ? ~r_last_grant : 1'b0;
    end else begin
      w_win = m1Req;
    end
    w_win_write = w_win ? m1Write  : m0Write;
    w_win_addr  = w_win ? m1Addr   : m0Addr;
    w_win_data  = w_win ? m1DataIn : m0DataIn;
    // An m1 write into register space (addr[13]) is acknowledged but never reaches the bus.
    w_win_guard = GUARD_REGS & w_win & w_win_write & w_win_addr[13];
    w_grant     = (r_state == S_IDLE) & w_any_req;
  end

  // Next-state logic. ISSUE, CAPTURE and ACK each last exactly one cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (w_any_req) w_state_next = S_ISSUE;
      S_ISSUE:   w_state_next = r_write ? S_ACK : S_CAPTURE;
      S_CAPTURE: w_state_next = S_ACK;
      S_ACK:     w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // State register. Reset abandons any transaction in flight.
  always_ff @(posedge busClk or negedge busResetN) begin
    if (!busResetN) r_state <= S_IDLE;
    else            r_state <= w_state_next;
  end

  // Latched transaction, registered bus strobes, acks and read data.
  always_ff @(posedge busClk or negedge busResetN) begin
    if (!busResetN) begin
      r_id         <= 1'b0;
      r_write      <= 1'b0;
      r_guard      <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
      r_last_grant <= 1'b1;
      r_rd_data    <= '0;
      r_m0_ack     <= 1'b0;
      r_m1_ack     <= 1'b0;
      r_m1_err     <= 1'b0;
      r_busy       <= 1'b0;
      r_bus_write  <= 1'b0;
      r_bus_read   <= 1'b0;
    end else begin
      r_bus_write <= 1'b0;
      r_bus_read  <= 1'b0;
      r_m0_ack    <= 1'b0;
      r_m1_ack    <= 1'b0;
      r_m1_err    <= 1'b0;
      r_busy      <= (w_state_next != S_IDLE);
      if (w_grant) begin
        r_id         <= w_win;
        r_write      <= w_win_write;
        r_guard      <= w_win_guard;
        r_addr       <= w_win_addr;
        r_data       <= w_win_data;
        r_last_grant <= w_win;
        r_bus_write  <= w_win_write & ~w_win_guard;
        r_bus_read   <= ~w_win_write;
      end
      if (w_state_next == S_ACK) begin
        r_m0_ack <= ~r_id;
        r_m1_ack <= r_id;
        r_m1_err <= r_guard;
      end
      // The neopixel module registers busDataOut, so it becomes valid during CAPTURE.
      if (r_state == S_CAPTURE) r_rd_data <= busDataOut;
    end
  end

  assign m0Ack     = r_m0_ack;
  assign m1Ack     = r_m1_ack;
  assign m1Err     = r_m1_err;
  assign rdData    = r_rd_data;
  assign busy      = r_busy;
  assign busAddr   = r_addr;
  assign busDataIn = r_data;
  assign busWrite  = r_bus_write;
  assign busRead   = r_bus_read;
  assign dbgState  = r_state;

endmodule
